// File: rtl/regfile_write_sched_if.sv
// Write-request bus between the writeback sources and the register-bank write scheduler,
// plus the scheduler's drive of the bank's single write port.
// Handshake: requester i holds req_valid[i], its rd slice and data slice stable until granted;
// a transfer happens in any cycle where req_valid[i] & req_ready[i]; dropping valid before the
// grant withdraws the request. req_ready depends only on req_valid and scheduler state.
interface regfile_write_sched_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]    req_valid;
   logic [5*NREQ-1:0]  req_rd;
   logic [32*NREQ-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               rf_we;
   logic [4:0]         rf_rd;
   logic [31:0]        rf_wdata;
   logic               busy;

   modport master (
      output req_valid, req_rd, req_data,
      input  req_ready, rf_we, rf_rd, rf_wdata, busy
   );

   modport slave (
      input  req_valid, req_rd, req_data,
      output req_ready, rf_we, rf_rd, rf_wdata, busy
   );
endinterface

// File: rtl/regfile_write_sched.sv
// Round-robin scheduler owning the register bank's single write port.
// Optional RF_INIT_EN: after every reset, zero x1..x31 and load x2 with SP_INIT before arbitrating.
module regfile_write_sched #(
   parameter int          NREQ    = 3,
   parameter logic [31:0] SP_INIT = 32'd512
) (
   input  logic                  clk,
   input  logic                  rst,
   regfile_write_sched_if.slave  bus,
   output logic                  dbg_state
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {ARB = 1'b0, INIT = 1'b1} state_t;

   state_t          state;
   logic [IW-1:0]   last;
   logic [IW-1:0]   gidx;
   logic [IW-1:0]   cand;
   logic            found;
   logic [NREQ-1:0] grant;
   logic [4:0]      g_rd;
   logic [31:0]     g_data;
   logic            rf_we_q;
   logic [4:0]      rf_rd_q;
   logic [31:0]     rf_wdata_q;
   int              t;

   // Search begins one past the last winner and wraps, so every waiting requester is served within NREQ grants.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      cand  = '0;
      grant = '0;
      t     = 0;
      if (state == ARB) begin
         for (int k = 1; k <= NREQ; k++) begin
            t = int'(last) + k;
            if (t >= NREQ) t = t - NREQ;
            cand = IW'(t);
            if (!found && bus.req_valid[cand]) begin
               found = 1'b1;
               gidx  = cand;
            end
         end
         if (found) grant[gidx] = 1'b1;
      end
   end

   assign g_rd   = bus.req_rd[int'(gidx)*5 +: 5];
   assign g_data = bus.req_data[int'(gidx)*32 +: 32];

`ifdef RF_INIT_EN
   logic [4:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= INIT;
         cnt        <= 5'd1;
         last       <= IW'(NREQ - 1);
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= 32'd0;
      end else if (state == INIT) begin
         rf_we_q    <= 1'b1;
         rf_rd_q    <= cnt;
         rf_wdata_q <= (cnt == 5'd2) ? SP_INIT : 32'd0;
         cnt        <= cnt + 5'd1;
         if (cnt == 5'd31) state <= ARB;
      end else if (found) begin
         last       <= gidx;
         rf_rd_q    <= g_rd;
         rf_wdata_q <= g_data;
         rf_we_q    <= (g_rd != 5'd0);
      end else begin
         rf_we_q    <= 1'b0;
      end
   end
`else
   logic unused_sp;

   assign state     = ARB;
   assign unused_sp = ^SP_INIT;

   always_ff @(posedge clk) begin
      if (rst) begin
         last       <= IW'(NREQ - 1);
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= 32'd0;
      end else if (found) begin
         last       <= gidx;
         rf_rd_q    <= g_rd;
         rf_wdata_q <= g_data;
         // Writes to x0 are consumed but never reach the bank.
         rf_we_q    <= (g_rd != 5'd0);
      end else begin
         rf_we_q    <= 1'b0;
      end
   end
`endif

   assign bus.req_ready = grant;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_rd     = rf_rd_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.busy      = (state == INIT);
   assign dbg_state     = (state == INIT);
endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for regfile_write_sched: vector table, hand-written reset/init corners and a
// randomized phase checked against a distance-based round-robin reference model.
module tb_regfile_write_sched;
   localparam int NREQ = 3;
`ifdef RF_INIT_EN
   localparam bit INIT_ON = 1'b1;
`else
   localparam bit INIT_ON = 1'b0;
`endif

   typedef struct {
      logic [2:0]  valid;
      logic [4:0]  rd   [3];
      logic [31:0] data [3];
      logic [2:0]  exp_ready;
      logic        exp_we;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dbg_state;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [31:0] bank [32];
   logic [37:0] exp_q [$];
   vec_t vecs [12];

   regfile_write_sched_if #(.NREQ(NREQ)) bus ();

   regfile_write_sched #(.NREQ(NREQ), .SP_INIT(32'd512)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / bank model ----------------
   always #5 clk = ~clk;

   initial for (int i = 0; i < 32; i++) bank[i] = 32'd0;

   always @(posedge clk) if (bus.rf_we) bank[bus.rf_rd] <= bus.rf_wdata;

   // ---------------- driver / check tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] data);
      bus.req_valid[i]       = v;
      bus.req_rd[5*i +: 5]   = rd;
      bus.req_data[32*i +: 32] = data;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NREQ; i++) drive_req(i, 1'b0, 5'd0, 32'd0);
   endtask

   function automatic vec_t mk(input logic [2:0] v,
                               input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [2:0] er, input logic ew, input logic [4:0] erd,
                               input logic [31:0] ed);
      vec_t x;
      x.valid = v;
      x.rd[0] = r0; x.rd[1] = r1; x.rd[2] = r2;
      x.data[0] = d0; x.data[1] = d1; x.data[2] = d2;
      x.exp_ready = er; x.exp_we = ew; x.exp_rd = erd; x.exp_data = ed;
      return x;
   endfunction

   // Ends one time step after a clock edge with the scheduler in ARB.
   task automatic do_reset();
      clear_reqs();
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_rf_we", 32'(bus.rf_we), 32'd0);
      check("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
      check("rst_rf_wdata", bus.rf_wdata, 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'(INIT_ON));
      check("rst_dbg_state", 32'(dbg_state), 32'(INIT_ON));
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef RF_INIT_EN
      for (int k = 1; k <= 31; k++) begin
         bus.req_valid = 3'($urandom_range(1, 7));
         #1;
         check("init_busy", 32'(bus.busy), 32'd1);
         check("init_ready_gated", 32'(bus.req_ready), 32'd0);
         @(posedge clk); #1;
         check("init_we", 32'(bus.rf_we), 32'd1);
         check("init_rd", 32'(bus.rf_rd), 32'(k));
         check("init_data", bus.rf_wdata, (k == 2) ? 32'd512 : 32'd0);
      end
      clear_reqs();
      check("init_done_busy", 32'(bus.busy), 32'd0);
`endif
   endtask

   // Applies one vector: drive, check combinational grant, then the registered write one cycle later.
   task automatic apply_vec(input vec_t x, input int idx);
      for (int i = 0; i < NREQ; i++) drive_req(i, x.valid[i], x.rd[i], x.data[i]);
      #2;
      check($sformatf("vec%0d_ready", idx), 32'(bus.req_ready), 32'(x.exp_ready));
      @(posedge clk); #1;
      check($sformatf("vec%0d_we", idx), 32'(bus.rf_we), 32'(x.exp_we));
      check($sformatf("vec%0d_rd", idx), 32'(bus.rf_rd), 32'(x.exp_rd));
      check($sformatf("vec%0d_data", idx), bus.rf_wdata, x.exp_data);
   endtask

   // ---------------- reference model for random phase ----------------
   logic        pend  [3];
   logic [4:0]  prd   [3];
   logic [31:0] pdata [3];
   int          waited [3];

   task automatic random_phase(input int cycles);
      int          mlast;
      logic [4:0]  m_rd;
      logic [31:0] m_data;
      int          best;
      int          bestd;
      int          d;
      logic [2:0]  exp_ready;
      logic [37:0] e;
      mlast  = NREQ - 1;
      m_rd   = INIT_ON ? 5'd31 : 5'd0;
      m_data = 32'd0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0; waited[i] = 0;
      end
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i] && $urandom_range(0, 15) == 0) begin
               pend[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i]   = 1'b1;
               prd[i]    = 5'($urandom_range(0, 31));
               pdata[i]  = $urandom;
               waited[i] = 0;
            end
            drive_req(i, pend[i], prd[i], pdata[i]);
         end
         #2;
         // Winner: pending requester closest after the last winner in circular order.
         best = -1; bestd = NREQ;
         for (int i = 0; i < NREQ; i++) begin
            d = (i - mlast - 1 + 2 * NREQ) % NREQ;
            if (pend[i] && d < bestd) begin
               best = i; bestd = d;
            end
         end
         exp_ready = (best >= 0) ? 3'(1 << best) : 3'd0;
         check("rand_ready", 32'(bus.req_ready), 32'(exp_ready));
         if (best >= 0) begin
            check("rand_fair_wait", 32'(waited[best] < NREQ), 32'd1);
            mlast = best; m_rd = prd[best]; m_data = pdata[best];
            exp_q.push_back({(prd[best] != 5'd0), prd[best], pdata[best]});
            pend[best] = 1'b0;
         end else begin
            exp_q.push_back({1'b0, m_rd, m_data});
         end
         for (int i = 0; i < NREQ; i++) if (pend[i]) waited[i]++;
         @(posedge clk); #1;
         e = exp_q.pop_front();
         check("rand_we", 32'(bus.rf_we), 32'(e[37]));
         check("rand_rd", 32'(bus.rf_rd), 32'(e[36:32]));
         check("rand_data", bus.rf_wdata, e[31:0]);
      end
      clear_reqs();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vecs[0]  = mk(3'b111, 5, 7, 9, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1'b1, 5,  32'hA0);
      vecs[1]  = mk(3'b111, 5, 7, 9, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1'b1, 7,  32'hA1);
      vecs[2]  = mk(3'b111, 5, 7, 9, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1'b1, 9,  32'hA2);
      vecs[3]  = mk(3'b111, 5, 7, 9, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1'b1, 5,  32'hA0);
      vecs[4]  = mk(3'b111, 5, 7, 9, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1'b1, 7,  32'hA1);
      vecs[5]  = mk(3'b111, 5, 7, 9, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1'b1, 9,  32'hA2);
      vecs[6]  = mk(3'b001, 5, 7, 9, 32'hDEADBEEF, 32'hA1, 32'hA2, 3'b001, 1'b1, 5, 32'hDEADBEEF);
      vecs[7]  = mk(3'b010, 5, 0, 9, 32'hA0, 32'h1234, 32'hA2, 3'b010, 1'b0, 0, 32'h1234);
      vecs[8]  = mk(3'b000, 5, 7, 9, 32'hA0, 32'hA1, 32'hA2, 3'b000, 1'b0, 0, 32'h1234);
      vecs[9]  = mk(3'b101, 3, 7, 31, 32'h11, 32'hA1, 32'hCAFEF00D, 3'b100, 1'b1, 31, 32'hCAFEF00D);
      vecs[10] = mk(3'b011, 3, 4, 9, 32'h11, 32'h22, 32'hA2, 3'b001, 1'b1, 3, 32'h11);
      vecs[11] = mk(3'b110, 3, 4, 6, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 4, 32'h22);

      clear_reqs();
      do_reset();
`ifdef RF_INIT_EN
      check("bank_x2_sp", bank[2], 32'd512);
`endif
      for (int v = 0; v < 12; v++) apply_vec(vecs[v], v);
      clear_reqs();

      // Requester 2 alone right after reset is granted at once and written one cycle later.
      do_reset();
      drive_req(2, 1'b1, 5'd12, 32'h5A5A5A5A);
      #2;
      check("first_ready", 32'(bus.req_ready), 32'b100);
      @(posedge clk); #1;
      check("first_we", 32'(bus.rf_we), 32'd1);
      check("first_rd", 32'(bus.rf_rd), 32'd12);
      check("first_data", bus.rf_wdata, 32'h5A5A5A5A);
      clear_reqs();

      // A grant in a reset cycle handshakes upstream but its write is dropped.
      rst = 1'b1;
      drive_req(0, 1'b1, 5'd8, 32'h77);
      #2;
      check("rstgrant_ready", 32'(bus.req_ready), 32'b001);
      @(posedge clk); #1;
      check("rstgrant_we", 32'(bus.rf_we), 32'd0);
      check("rstgrant_rd", 32'(bus.rf_rd), 32'd0);
      check("rstgrant_data", bus.rf_wdata, 32'd0);
      clear_reqs();

`ifdef RF_INIT_EN
      // Reset mid-init (cnt==17) restarts the whole sequence from x1.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
      end
      check("abort_rd16", 32'(bus.rf_rd), 32'd16);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_we", 32'(bus.rf_we), 32'd0);
      check("abort_rd", 32'(bus.rf_rd), 32'd0);
      check("abort_data", bus.rf_wdata, 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd1);
`endif

      do_reset();
      random_phase(400);
      @(posedge clk); #1;
      check("bank_x0_zero", bank[0], 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 32×32 register bank. It owns the bank's single write port (`regWrite1`/`rd1`/`dataIn`). After reset it runs an init sequence that zeroes x1..x31 and loads the stack pointer x2. It then shares the write port among `NREQ` writeback requesters with round-robin arbitration. Sits between the writeback sources (ALU, load unit, CSR/misc) and the register bank.

## Interface
- `NREQ`, 3: number of writeback requesters (2..8).
- `SP_INIT`, 32'd512: value written to x2 during init.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_rd`  in  5*NREQ  destination register; slice i is bits [5i+4:5i].
- `req_data`  in  32*NREQ  write data; slice i is bits [32i+31:32i].
- `req_ready`  out  NREQ  one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `rf_we`  out  1  drives bank `regWrite1`.
- `rf_rd`  out  5  drives bank `rd1`.
- `rf_wdata`  out  32  drives bank `dataIn`.
- `busy`  out  1  high while the init sequence is running.

## Operation
- States: INIT and ARB.
- Reset state and counters:
  - With `RF_INIT_EN`: state=INIT, cnt=1.
  - Without it: state=ARB.
  - Round-robin pointer `last`=NREQ-1, so requester 0 has first priority.
- INIT, each cycle:
  - Register rf_we=1, rf_rd=cnt, rf_wdata=(cnt==2 ? SP_INIT : 0).
  - cnt increments. When cnt==31 is issued, the next state is ARB.
  - `req_ready`=0 throughout INIT.
- ARB:
  - Search starts at `last+1` mod NREQ, wrapping. The first i with `req_valid[i]`=1 gets `req_ready[i]`=1 (combinational); all other bits are 0.
  - If no valid: `req_ready`=0, `last` unchanged.
  - On a transfer from requester g:
    - `last`<=g.
    - Register rf_rd=req_rd[g], rf_wdata=req_data[g].
    - rf_we=(req_rd[g]!=0). A write to x0 is accepted and consumed but suppressed at the port.
  - No transfer: rf_we<=0; rf_rd and rf_wdata hold.
- `req_ready` never depends on the requester's own rd or data, only on `req_valid` and state.
- A requester must hold valid, rd and data stable until it is granted. Dropping valid before grant is permitted and simply withdraws the request.
- `busy`=(state==INIT), decoded combinationally from state.

## Timing
- Reset values:
  - rf_we=0, rf_rd=0, rf_wdata=0, req_ready=0.
  - busy=1 with `RF_INIT_EN`, 0 without.
- Init sequence:
  - First init write is presented on the first cycle after `rst` deasserts. The last one (x31) is presented 31 cycles after.
  - busy falls on the same cycle x31 is presented; ARB grants are possible from that cycle on.
- Write latency:
  - A grant in cycle N presents rf_we/rf_rd/rf_wdata in cycle N+1.
  - The bank captures the write at the end of N+1, and a read sees the new value in N+2.
- Throughput: one write per cycle. Under continuous contention among k requesters, each requester is granted within k cycles.
- `rst` asserted mid-INIT or mid-ARB:
  - Next edge restores all reset values, and init restarts at cnt=1.
  - A grant issued in the cycle `rst` is high still completes its handshake upstream, but its write is discarded.

## Configuration
- `RF_INIT_EN` defined:
  - INIT state and 5-bit counter are compiled in; 31-cycle init after every reset.
- `RF_INIT_EN` not defined:
  - No INIT state; ARB from the first cycle after reset.
  - busy is tied to 0 and `SP_INIT` is unused.
  - Software or the bank's own initial contents set x2.

## Test plan
- Reset then release with `RF_INIT_EN`, no requests: writes rd=1..31 in consecutive cycles, all data 0 except rd=2 -> 512. busy high for exactly 31 cycles, then low. `req_ready` stays 0 while busy.
- Single request in ARB: req_valid=3'b001, rd=5, data=0xDEADBEEF: `req_ready`=3'b001 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
- All three valid continuously for 6 cycles from reset pointer: grant order 0,1,2,0,1,2, with one rf_we pulse per cycle.
- Requester 1 writes rd=0 with data 0x1234: grant asserted; next cycle rf_we=0. A bank read of x0 returns 0.
- `rst` asserted at init cnt=17: outputs return to reset values; after release the sequence restarts at rd=1 and runs the full 31 writes.
- Build without `RF_INIT_EN`: busy=0 after reset; req_valid=3'b100 on the first post-reset cycle is granted immediately and written one cycle later.
